// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, ALU operation and write enables.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

module mc_ctrl
    import mc_pkg::*;
#(
    parameter int RDY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);
    localparam int CW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
    localparam bit TO_EN = (RDY_TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = CW'((RDY_TIMEOUT > 0) ? RDY_TIMEOUT - 1 : 0);

    state_t        st;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          waiting;
    logic          r_ok;
    logic          r_shift;
    logic [3:0]    r_op;
    logic [3:0]    i_op;
    logic          i_sx;

    assign waiting = !mem_rdy &&
                     (st == S_FETCH || st == S_MEMRD || st == S_MEMWR);

    always_comb begin
        r_ok    = 1'b1;
        r_shift = 1'b0;
        r_op    = ALU_ADD;
        case (Funct)
            6'h20, 6'h21: r_op = ALU_ADD;
            6'h22, 6'h23: r_op = ALU_SUB;
            6'h24:        r_op = ALU_AND;
            6'h25:        r_op = ALU_OR;
            6'h26:        r_op = ALU_XOR;
            6'h27:        r_op = ALU_NOR;
            6'h2A:        r_op = ALU_SLT;
            6'h2B:        r_op = ALU_SLTU;
            6'h00, 6'h04: begin r_op = ALU_SLL; r_shift = 1'b1; end
            6'h02, 6'h06: begin r_op = ALU_SRL; r_shift = 1'b1; end
            6'h03, 6'h07: begin r_op = ALU_SRA; r_shift = 1'b1; end
            default:      r_ok = 1'b0;
        endcase
    end

    // Logical immediates zero-extend; arithmetic/compare ones sign-extend
    always_comb begin
        i_op = ALU_ADD;
        i_sx = 1'b1;
        case (Op)
            OP_ANDI:  begin i_op = ALU_AND; i_sx = 1'b0; end
            OP_ORI:   begin i_op = ALU_OR;  i_sx = 1'b0; end
            OP_SLTI:  i_op = ALU_SLT;
            OP_SLTIU: i_op = ALU_SLTU;
            default:  ;
        endcase
    end

    always_comb begin
        nxt = st;
        case (st)
            S_FETCH:  if (mem_rdy) nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:     nxt = S_MEMADR;
                    OP_RTYPE:         nxt = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_SLTIU: nxt = S_IEXEC;
                    OP_BEQ, OP_BNE:   nxt = S_BRANCH;
                    OP_J:             nxt = S_JUMP;
                    default:          nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) nxt = S_MEMWB;
            S_MEMWR:  if (mem_rdy) nxt = S_FETCH;
            S_EXEC:   nxt = r_ok ? S_ALUWB : S_ILLEGAL;
            S_IEXEC:  nxt = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB,
            S_BRANCH, S_JUMP: nxt = S_FETCH;
            default:  nxt = S_ILLEGAL;
        endcase
        if (TO_EN && waiting && cnt == TO_LAST)
            nxt = S_ILLEGAL;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st  <= S_FETCH;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= (waiting && nxt == st) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        EXTOp    = 1'b0;
        ALUOp    = ALU_ADD;
        PCSource = 2'd0;
        case (st)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                EXTOp   = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                EXTOp   = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = r_shift ? 2'd2 : 2'd1;
                ALUOp   = r_op;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp   = i_op;
                EXTOp   = i_sx;
            end
            S_IWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 2'd1;
                ALUOp    = ALU_SUB;
                PCSource = 2'd1;
                PCWrite  = (Op == OP_BNE) ? !Zero : Zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            default: ;
        endcase
        // Enables stay low for the whole reset, not just after the next edge
        if (!rstn) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state   = st;
    assign illegal = (st == S_ILLEGAL);
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected state/controls are queued
// with their mem_rdy/Zero stimulus and compared as the FSM steps.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_rdy;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite;
    logic       RegWrite, RegDst, MemtoReg, EXTOp, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp, state;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(.RDY_TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_rdy(mem_rdy), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [19:0] ctl;
    assign ctl = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, EXTOp, ALUOp,
                  PCSource, illegal};

    typedef struct {
        logic        rdy;
        logic        zero;
        logic [3:0]  st;
        logic [19:0] c;
        string       tag;
    } ent_t;

    ent_t q[$];

    function automatic logic [19:0] cv(
        input logic pcw, input logic irw, input logic iord,
        input logic mr, input logic mw, input logic rw,
        input logic rd, input logic m2r, input logic [1:0] sa,
        input logic [1:0] sb, input logic ex, input logic [3:0] op,
        input logic [1:0] ps, input logic il);
        return {pcw, irw, iord, mr, mw, rw, rd, m2r, sa, sb, ex, op, ps, il};
    endfunction

    task automatic push(input logic rdy, input logic zero,
                        input logic [3:0] st, input logic [19:0] c,
                        input string tag);
        ent_t e;
        e.rdy = rdy; e.zero = zero; e.st = st; e.c = c; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic p_fetch(input logic rdy, input string t);
        push(rdy, 1'b0, 4'd0, cv(rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd1, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/fetch"});
    endtask
    task automatic p_decode(input string t);
        push(1'b1, 1'b0, 4'd1, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd3, 1'b1, ALU_ADD, 2'd0, 1'b0), {t, "/decode"});
    endtask
    task automatic p_memadr(input string t);
        push(1'b1, 1'b0, 4'd2, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd1, 2'd2, 1'b1, ALU_ADD, 2'd0, 1'b0), {t, "/memadr"});
    endtask
    task automatic p_memrd(input logic rdy, input string t);
        push(rdy, 1'b0, 4'd3, cv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/memrd"});
    endtask
    task automatic p_memwb(input string t);
        push(1'b1, 1'b0, 4'd4, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/memwb"});
    endtask
    task automatic p_memwr(input logic rdy, input string t);
        push(rdy, 1'b0, 4'd5, cv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/memwr"});
    endtask
    task automatic p_exec(input logic [1:0] sa, input logic [3:0] op,
                          input string t);
        push(1'b1, 1'b0, 4'd6, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, sa, 2'd0, 1'b0, op, 2'd0, 1'b0), {t, "/exec"});
    endtask
    task automatic p_aluwb(input string t);
        push(1'b1, 1'b0, 4'd7, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/aluwb"});
    endtask
    task automatic p_iexec(input logic [3:0] op, input logic ex,
                           input string t);
        push(1'b1, 1'b0, 4'd8, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd1, 2'd2, ex, op, 2'd0, 1'b0), {t, "/iexec"});
    endtask
    task automatic p_iwb(input string t);
        push(1'b1, 1'b0, 4'd9, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b0), {t, "/iwb"});
    endtask
    task automatic p_branch(input logic zero, input logic pcw,
                            input string t);
        push(1'b1, zero, 4'd10, cv(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd1, 2'd0, 1'b0, ALU_SUB, 2'd1, 1'b0), {t, "/branch"});
    endtask
    task automatic p_jump(input string t);
        push(1'b1, 1'b0, 4'd11, cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd2, 1'b0), {t, "/jump"});
    endtask
    task automatic p_illegal(input logic rdy, input string t);
        push(rdy, 1'b0, 4'd15, cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 2'd0, 2'd0, 1'b0, ALU_ADD, 2'd0, 1'b1), {t, "/illegal"});
    endtask

    // Entered at posedge+2; drives, checks at +3, returns at next posedge+2
    task automatic drain();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_rdy = e.rdy;
            Zero = e.zero;
            #1;
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state got %0d want %0d", e.tag, state, e.st);
            end
            checks++;
            if (ctl !== e.c) begin
                errors++;
                $display("FAIL %s ctl got %h want %h", e.tag, ctl, e.c);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        mem_rdy = 1'b1;
        Zero = 1'b0;
        Op = 6'h00;
        Funct = 6'h20;
        @(posedge clk);
        #2;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_en got %b want 000000",
                     {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal});
        end
        mem_rdy = 1'b0;
        rstn = 1'b1;
        #1;
        checks++;
        if ({MemRead, IRWrite, state} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_release got mr=%b irw=%b st=%0d want mr=1 irw=0 st=0",
                     MemRead, IRWrite, state);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_add();
        Op = 6'h00;
        Funct = 6'h20;
        p_fetch(1'b1, "add");
        p_decode("add");
        p_exec(2'd1, ALU_ADD, "add");
        p_aluwb("add");
        drain();
    endtask

    task automatic test_rtype_table();
        logic [5:0] fn [6] = '{6'h00, 6'h06, 6'h03, 6'h23, 6'h2A, 6'h27};
        logic [3:0] op [6] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB, ALU_SLT, ALU_NOR};
        logic [1:0] sa [6] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
        Op = 6'h00;
        for (int i = 0; i < 6; i++) begin
            Funct = fn[i];
            p_fetch(1'b1, $sformatf("rt%0d", i));
            p_decode($sformatf("rt%0d", i));
            p_exec(sa[i], op[i], $sformatf("rt%0d", i));
            p_aluwb($sformatf("rt%0d", i));
            drain();
        end
    endtask

    task automatic test_lw_stall();
        Op = 6'h23;
        p_fetch(1'b1, "lw");
        p_decode("lw");
        p_memadr("lw");
        for (int i = 0; i < 3; i++) p_memrd(1'b0, "lw");
        p_memrd(1'b1, "lw");
        p_memwb("lw");
        drain();
    endtask

    task automatic test_sw();
        Op = 6'h2B;
        p_fetch(1'b1, "sw");
        p_decode("sw");
        p_memadr("sw");
        p_memwr(1'b1, "sw");
        drain();
    endtask

    task automatic test_itype();
        logic [5:0] opc [5] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0B};
        logic [3:0] aop [5] = '{ALU_ADD, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU};
        logic       ext [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            Op = opc[i];
            p_fetch(1'b1, $sformatf("it%0d", i));
            p_decode($sformatf("it%0d", i));
            p_iexec(aop[i], ext[i], $sformatf("it%0d", i));
            p_iwb($sformatf("it%0d", i));
            drain();
        end
    endtask

    task automatic test_branch();
        logic [5:0] opc [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pw  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            Op = opc[i];
            p_fetch(1'b1, $sformatf("br%0d", i));
            p_decode($sformatf("br%0d", i));
            p_branch(z[i], pw[i], $sformatf("br%0d", i));
            drain();
        end
    endtask

    task automatic test_jump();
        Op = 6'h02;
        p_fetch(1'b1, "j");
        p_decode("j");
        p_jump("j");
        drain();
    endtask

    task automatic test_fetch_stall();
        Op = 6'h02;
        p_fetch(1'b0, "fstall");
        p_fetch(1'b0, "fstall");
        p_fetch(1'b1, "fstall");
        p_decode("fstall");
        p_jump("fstall");
        drain();
    endtask

    task automatic test_timeout();
        Op = 6'h02;
        for (int i = 0; i < 16; i++) p_fetch(1'b0, $sformatf("to%0d", i));
        p_illegal(1'b0, "to");
        p_illegal(1'b1, "to_hold");
        drain();
        rstn = 1'b0;
        #1;
        checks++;
        if ({illegal, state} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL to_reset got il=%b st=%0d want il=0 st=0", illegal, state);
        end
        mem_rdy = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_illegal_op();
        Op = 6'h3F;
        p_fetch(1'b1, "badop");
        p_decode("badop");
        for (int i = 0; i < 3; i++) p_illegal(1'b1, "badop");
        drain();
        rstn = 1'b0;
        #1;
        checks++;
        if ({illegal, state} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL badop_reset got il=%b st=%0d want il=0 st=0", illegal, state);
        end
        mem_rdy = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_bad_funct();
        Op = 6'h00;
        Funct = 6'h01;
        p_fetch(1'b1, "badfn");
        p_decode("badfn");
        p_exec(2'd1, ALU_ADD, "badfn");
        p_illegal(1'b1, "badfn");
        drain();
        rstn = 1'b0;
        #1;
        checks++;
        if ({illegal, state} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL badfn_reset got il=%b st=%0d want il=0 st=0", illegal, state);
        end
        mem_rdy = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset_mid();
        Op = 6'h2B;
        p_fetch(1'b1, "rmid");
        p_decode("rmid");
        p_memadr("rmid");
        p_memwr(1'b0, "rmid");
        drain();
        rstn = 1'b0;
        #1;
        checks++;
        if ({state, MemWrite} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_async got st=%0d mw=%b want st=0 mw=0", state, MemWrite);
        end
        mem_rdy = 1'b1;
        @(posedge clk);
        #3;
        checks++;
        if ({state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 9'b0) begin
            errors++;
            $display("FAIL rmid_hold got st=%0d en=%b want st=0 en=00000", state,
                     {PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
        end
        mem_rdy = 1'b0;
        rstn = 1'b1;
        #1;
        checks++;
        if ({state, MemRead, MemWrite} !== {4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rmid_release got st=%0d mr=%b mw=%b want st=0 mr=1 mw=0",
                     state, MemRead, MemWrite);
        end
        @(posedge clk);
        #2;
        p_fetch(1'b1, "rmid_after");
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_rtype_table();
        test_lw_stall();
        test_sw();
        test_itype();
        test_branch();
        test_jump();
        test_fetch_stall();
        test_timeout();
        test_illegal_op();
        test_bad_funct();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
